// File: rtl/rsa_seq_pkg.sv
// Shared types and constants for the RSA job sequencer and its watchdog.
// Holds the sequencer state encoding and the result status codes.
package rsa_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_ARM,
    S_WAIT,
    S_RESP
  } seq_state_e;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_REJECT  = 2'b10;

endpackage

// File: rtl/seq_watchdog.sv
// Saturating cycle counter with clear/enable and a flag that reports when
// the count including the current cycle reaches TIMEOUT.
module seq_watchdog #(
  parameter int CYC_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CYC_W-1:0] cnt_inc,
  output logic             limit_hit
);

  localparam logic [CYC_W-1:0] CNT_MAX = '1;
  localparam logic [CYC_W-1:0] LIMIT   = CYC_W'(TIMEOUT);

  logic [CYC_W-1:0] cnt_q;
  logic [CYC_W-1:0] cnt_d;

  // cnt_inc is the value the counter holds once the current cycle is counted;
  // it sticks at CNT_MAX instead of wrapping.
  always_comb begin
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    cnt_d   = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_inc;
    end
  end

  assign limit_hit = (cnt_inc == LIMIT);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, regardless of process ordering in simulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rsa_job_sequencer.sv
// Initiator side of the iteration-engine start/done handshake: accepts host
// jobs, pulses the engine start, watches done under a watchdog, returns results.
module rsa_job_sequencer
  import rsa_seq_pkg::*;
#(
  parameter int KEY_W   = 6,
  parameter int TAG_W   = 4,
  parameter int CYC_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [KEY_W-1:0] job_key,
  input  logic [TAG_W-1:0] job_tag,
  output logic             eng_start,
  output logic [KEY_W-1:0] eng_key,
  input  logic             eng_done,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [TAG_W-1:0] res_tag,
  output logic [1:0]       res_status,
  output logic [CYC_W-1:0] res_cycles,
  output logic             busy
);

  seq_state_e       state_q,  state_d;
  logic [KEY_W-1:0] key_q,    key_d;
  logic [TAG_W-1:0] tag_q,    tag_d;
  logic [1:0]       status_q, status_d;
  logic [CYC_W-1:0] cycles_q, cycles_d;
  logic             rdy_q,    rdy_d;

  logic             wd_clr;
  logic             wd_en;
  logic [CYC_W-1:0] wd_cnt_inc;
  logic             wd_limit_hit;

  seq_watchdog #(
    .CYC_W   (CYC_W),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clr       (wd_clr),
    .en        (wd_en),
    .cnt_inc   (wd_cnt_inc),
    .limit_hit (wd_limit_hit)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    tag_d    = tag_q;
    status_d = status_q;
    cycles_d = cycles_q;
    rdy_d    = 1'b1;
    wd_clr   = (state_q == S_LAUNCH);
    wd_en    = (state_q == S_ARM) || (state_q == S_WAIT);

    case (state_q)
      S_IDLE: begin
        if (job_valid && job_ready) begin
          key_d = job_key;
          tag_d = job_tag;
          if (job_key == '0) begin
            status_d = ST_REJECT;
            cycles_d = '0;
            state_d  = S_RESP;
          end else begin
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: state_d = S_ARM;
      // A done level left over from the previous job is still visible here.
      S_ARM:    state_d = S_WAIT;
      S_WAIT: begin
        if (eng_done) begin
          status_d = ST_OK;
          cycles_d = wd_cnt_inc;
          state_d  = S_RESP;
        end else if (wd_limit_hit) begin
          status_d = ST_TIMEOUT;
          cycles_d = CYC_W'(TIMEOUT);
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      key_q    <= '0;
      tag_q    <= '0;
      status_q <= ST_OK;
      cycles_q <= '0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      tag_q    <= tag_d;
      status_q <= status_d;
      cycles_q <= cycles_d;
      rdy_q    <= rdy_d;
    end
  end

  // rdy_q keeps job_ready low while reset is held, even though state is IDLE.
  assign job_ready  = rdy_q && (state_q == S_IDLE);
  assign eng_start  = (state_q == S_LAUNCH);
  assign eng_key    = key_q;
  assign res_valid  = (state_q == S_RESP);
  assign res_tag    = tag_q;
  assign res_status = status_q;
  assign res_cycles = cycles_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_rsa_job_sequencer.sv
// Self-checking bench for rsa_job_sequencer: engine model plus a scoreboard of
// expected results pushed at job acceptance and compared at the result handshake.
module tb_rsa_job_sequencer;
  import rsa_seq_pkg::*;

  localparam int KEY_W   = 6;
  localparam int TAG_W   = 4;
  localparam int CYC_W   = 8;
  localparam int TIMEOUT = 200;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             job_valid = 1'b0;
  logic             job_ready;
  logic [KEY_W-1:0] job_key = '0;
  logic [TAG_W-1:0] job_tag = '0;
  logic             eng_start;
  logic [KEY_W-1:0] eng_key;
  logic             eng_done;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [TAG_W-1:0] res_tag;
  logic [1:0]       res_status;
  logic [CYC_W-1:0] res_cycles;
  logic             busy;

  rsa_job_sequencer #(
    .KEY_W(KEY_W), .TAG_W(TAG_W), .CYC_W(CYC_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_key(job_key), .job_tag(job_tag),
    .eng_start(eng_start), .eng_key(eng_key), .eng_done(eng_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
    .res_status(res_status), .res_cycles(res_cycles), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [1:0]       status;
    logic [CYC_W-1:0] cycles;
    logic [1:0]       starts;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   start_cnt = 0;

  // Engine model: after a start, done rises eng_delay cycles after the start
  // cycle and stays high until the next start. eng_delay==0 means never.
  // stale_drop keeps the old done visible through the cycle after start.
  int eng_delay  = 0;
  bit stale_drop = 1'b0;
  int ecnt = 0;
  bit erun = 1'b0;

  always @(posedge clk) begin
    if (eng_start) begin
      ecnt <= 1;
      erun <= 1'b1;
    end else if (erun && ecnt < 100000) begin
      ecnt <= ecnt + 1;
    end
  end

  assign eng_done = erun && ((eng_delay > 0 && ecnt >= eng_delay) || (stale_drop && ecnt <= 1));

  always @(negedge clk) if (eng_start) start_cnt++;

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({job_ready, eng_start, eng_key, res_valid, res_tag, res_status, res_cycles, busy} !==
        {1'b0, 1'b0, {KEY_W{1'b0}}, 1'b0, {TAG_W{1'b0}}, 2'b00, {CYC_W{1'b0}}, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_values: got rdy=%b start=%b key=%h rv=%b tag=%h st=%b cyc=%0d busy=%b",
               job_ready, eng_start, eng_key, res_valid, res_tag, res_status, res_cycles, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (job_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL ready_before_edge: got %b want 0", job_ready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (job_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL ready_after_release: got %b want 1", job_ready);
    end
  endtask

  // Offers one job, pushes its expected result, and checks the cycle after accept.
  task automatic send_job(input logic [KEY_W-1:0] key, input logic [TAG_W-1:0] tag,
                          input int delay, input bit stale,
                          input logic [1:0] st, input logic [CYC_W-1:0] cyc, input string name);
    bit   acc = 1'b0;
    exp_t e;
    eng_delay  = delay;
    stale_drop = stale;
    start_cnt  = 0;
    job_key    = key;
    job_tag    = tag;
    job_valid  = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      if (job_ready) acc = 1'b1;
      @(posedge clk);
      #1;
    end
    job_valid = 1'b0;
    n_checks++;
    if (!acc) begin
      n_errors++;
      $display("FAIL %s_accept: job_ready never seen within 50 cycles", name);
    end
    e.tag    = tag;
    e.status = st;
    e.cycles = cyc;
    e.starts = (key != '0) ? 2'd1 : 2'd0;
    exp_q.push_back(e);
    n_checks++;
    if ({eng_start, res_valid, busy, job_ready} !== {(key != '0), (key == '0), 1'b1, 1'b0}) begin
      n_errors++;
      $display("FAIL %s_after_accept: got start=%b rv=%b busy=%b rdy=%b want start=%b rv=%b busy=1 rdy=0",
               name, eng_start, res_valid, busy, job_ready, (key != '0), (key == '0));
    end
    if (key != '0) begin
      n_checks++;
      if (eng_key !== key) begin
        n_errors++;
        $display("FAIL %s_eng_key: got %h want %h", name, eng_key, key);
      end
    end
  endtask

  // Waits for res_valid, holds off res_ready for hold cycles, then compares.
  task automatic collect(input int hold, input string name);
    bit   got = 1'b0;
    exp_t e;
    logic [TAG_W+2+CYC_W-1:0] snap;
    for (int i = 0; i < 400; i++) begin
      if (res_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL %s_res_valid: no result within 400 cycles", name);
      return;
    end
    snap = {res_tag, res_status, res_cycles};
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if ({res_valid, job_ready, busy, res_tag, res_status, res_cycles} !== {1'b1, 1'b0, 1'b1, snap}) begin
        n_errors++;
        $display("FAIL %s_hold%0d: got rv=%b rdy=%b busy=%b res=%h want rv=1 rdy=0 busy=1 res=%h",
                 name, i, res_valid, job_ready, busy, {res_tag, res_status, res_cycles}, snap);
      end
    end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s_scoreboard: result with no expected entry", name);
    end else begin
      e = exp_q.pop_front();
      if ({res_tag, res_status, res_cycles, start_cnt[1:0]} !== {e.tag, e.status, e.cycles, e.starts}) begin
        n_errors++;
        $display("FAIL %s_result: got tag=%h st=%b cyc=%0d starts=%0d want tag=%h st=%b cyc=%0d starts=%0d",
                 name, res_tag, res_status, res_cycles, start_cnt, e.tag, e.status, e.cycles, e.starts);
      end
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    n_checks++;
    if ({job_ready, res_valid, busy} !== 3'b100) begin
      n_errors++;
      $display("FAIL %s_after_handshake: got rdy=%b rv=%b busy=%b want 1 0 0",
               name, job_ready, res_valid, busy);
    end
  endtask

  task automatic test_nominal();
    send_job(6'd5, 4'd3, 4, 1'b0, ST_OK, 8'd4, "nominal");
    collect(0, "nominal");
  endtask

  task automatic test_zero_key();
    send_job(6'd0, 4'd7, 4, 1'b0, ST_REJECT, 8'd0, "zero_key");
    collect(2, "zero_key");
  endtask

  task automatic test_timeout();
    send_job(6'd10, 4'd1, 0, 1'b0, ST_TIMEOUT, 8'(TIMEOUT), "timeout");
    collect(3, "timeout");
  endtask

  task automatic test_stale_backpressure();
    send_job(6'd3, 4'd2, 3, 1'b0, ST_OK, 8'd3, "pre_stale");
    collect(0, "pre_stale");
    send_job(6'd6, 4'd4, 6, 1'b1, ST_OK, 8'd6, "stale");
    collect(10, "stale");
  endtask

  task automatic test_done_at_limit();
    send_job(6'd20, 4'd6, TIMEOUT, 1'b0, ST_OK, 8'(TIMEOUT), "done_at_limit");
    collect(0, "done_at_limit");
    send_job(6'd21, 4'd8, TIMEOUT - 1, 1'b0, ST_OK, 8'(TIMEOUT - 1), "done_before_limit");
    collect(1, "done_before_limit");
  endtask

  task automatic test_reset_mid_wait();
    exp_t e;
    send_job(6'd9, 4'd9, 0, 1'b0, ST_TIMEOUT, 8'(TIMEOUT), "mid_reset");
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({job_ready, eng_start, eng_key, res_valid, res_tag, res_status, res_cycles, busy} !==
        {1'b0, 1'b0, {KEY_W{1'b0}}, 1'b0, {TAG_W{1'b0}}, 2'b00, {CYC_W{1'b0}}, 1'b0}) begin
      n_errors++;
      $display("FAIL mid_reset_async: got rdy=%b start=%b key=%h rv=%b tag=%h st=%b cyc=%0d busy=%b",
               job_ready, eng_start, eng_key, res_valid, res_tag, res_status, res_cycles, busy);
    end
    if (exp_q.size() > 0) e = exp_q.pop_back();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({job_ready, busy} !== 2'b00) begin
      n_errors++;
      $display("FAIL mid_reset_held: got rdy=%b busy=%b want 0 0", job_ready, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    send_job(6'd2, 4'd5, 2, 1'b0, ST_OK, 8'd2, "post_reset");
    collect(0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_zero_key();
    test_timeout();
    test_stale_backpressure();
    test_done_at_limit();
    test_reset_mid_wait();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rsa_job_sequencer.md
# rsa_job_sequencer

Initiator side of the iteration-engine start/done handshake. Accepts exponentiation jobs from the host over a valid/ready channel. It launches the iteration counter engine with a single-cycle start pulse and a stable key, then waits for the engine's done level under a watchdog. It returns a tagged result (status plus measured cycle count) over a second valid/ready channel. Sits between the host/command interface and the RSA iteration engine.

## Interface
- KEY_W, 6, width of exponent/key word passed to engine
- TAG_W, 4, width of host job tag
- CYC_W, 8, width of cycle/watchdog counter
- TIMEOUT, 200, WAIT-phase cycle limit before timeout (must be < 2^CYC_W)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- job_valid  in  1  host job offered
- job_ready  out  1  sequencer can accept job
- job_key  in  KEY_W  iteration count for engine
- job_tag  in  TAG_W  opaque host tag
- eng_start  out  1  one-cycle launch pulse to engine
- eng_key  out  KEY_W  key to engine, stable from LAUNCH until return to IDLE
- eng_done  in  1  engine done level (stays high until next start)
- res_valid  out  1  result available
- res_ready  in  1  host takes result
- res_tag  out  TAG_W  tag of completed job
- res_status  out  2  00 ok, 01 timeout, 10 rejected (zero key), 11 unused
- res_cycles  out  CYC_W  cycles spent in ARM+WAIT
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, LAUNCH, ARM, WAIT, RESP.
- IDLE: job_ready=1. On job_valid&&job_ready, latch key and tag.
  - If job_key==0: next state RESP, status 10, cycles 0. No eng_start is issued.
  - Otherwise: next state LAUNCH.
- LAUNCH: eng_start=1 for exactly this cycle. Clear the cycle counter. Next state ARM.
- ARM: eng_done is ignored, because a stale done from the previous job is still high. Counter +1. Next state WAIT.
- WAIT: counter +1 every cycle.
  - If eng_done==1: status 00, res_cycles=counter including this cycle, next state RESP.
  - Else if counter==TIMEOUT: status 01, res_cycles=TIMEOUT, next state RESP.
  - If done and timeout fall on the same cycle, done wins (status 00).
- RESP: res_valid=1. tag, status and cycles are held stable. On res_ready, next state IDLE.
- Counter saturates at 2^CYC_W-1 and never wraps.
- Reset mid-job: all state is discarded immediately and eng_start drops asynchronously. The engine is not notified; a subsequent job relaunches it, because the start pulse re-arms it.

## Timing
- Reset values:
  - job_ready=0 while reset is asserted, 1 in the first cycle after release.
  - eng_start=0, eng_key=0, res_valid=0, res_tag=0, res_status=00, res_cycles=0, busy=0.
  - Internal state is IDLE.
- All outputs are registered or decoded from the registered state only; there is no combinational path from any input to any output.
- Job accepted at edge t:
  - eng_start high in cycle t+1.
  - First done sample in cycle t+3.
  - Earliest res_valid in cycle t+4.
- Rejected job accepted at edge t: res_valid high in cycle t+1.
- Result handshake at edge r: job_ready high in cycle r+1. There is no back-to-back accept in the same cycle as the result handshake.
- eng_key changes only on job acceptance.

## Structure
- Package rsa_seq_pkg holds:
  - state enum.
  - status constants ST_OK=2'b00, ST_TIMEOUT=2'b01, ST_REJECT=2'b10.
- One natural sub-module, seq_watchdog, provides:
  - saturating CYC_W counter with clear/enable inputs.
  - a limit-reached flag compared against TIMEOUT.
- Everything else (FSM, job/result registers) lives in rsa_job_sequencer.

## Test plan
- Nominal: key=5, tag=3; engine model raises done 4 cycles after start. Required: exactly one eng_start pulse, eng_key=5, status 00, res_cycles=4, res_tag=3.
- Zero key: key=0, tag=7. Required: no eng_start, res_valid one cycle after accept, status 10, cycles 0.
- Timeout: engine never raises done, TIMEOUT=200. Required: status 01, res_cycles=200, res_valid stable until res_ready.
- Stale done and backpressure:
  - eng_done held high from the previous job, and the new engine model drops it one cycle after start. Required: the stale done is not taken as completion.
  - res_ready held low 10 cycles. Required: outputs hold, job_ready=0 throughout, job_ready=1 the cycle after the handshake.
- Done on the timeout cycle: done asserted exactly when counter==TIMEOUT. Required: status 00.
- Reset mid-WAIT: rst low for 2 cycles. Required: all outputs at reset values asynchronously, a new key=2 job completes normally.
